qdr_lvds_rx: RTL and testbench

// Receive end of the 4-lane LVDS DAC link: deserialises DA[3:0] plus the forwarded DACLK/DAFRAME pairs back into 14-bit samples.

---
 rtl/qdr_lvds_rx_if.sv | 28 ++
 rtl/qdr_lvds_rx.sv | 151 +++++++++++++++
 tb/tb_qdr_lvds_rx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/qdr_lvds_rx_if.sv
// Receive-side bundle of the 4-lane LVDS DAC link.
// Carries the serial lanes, the forwarded clock/frame pairs and the recovered-sample outputs.
interface qdr_lvds_rx_if #(
    parameter int DATA_W = 14,
    parameter int LANES  = 4
);
    logic [LANES-1:0]  DA;
    logic              DACLKP;
    logic              DACLKM;
    logic              DAFRAMEP;
    logic              DAFRAMEM;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              locked;
    logic              frame_err;
    logic              pad_err;
    logic              diff_err;

    modport master (
        output DA, DACLKP, DACLKM, DAFRAMEP, DAFRAMEM,
        input  data_out, data_valid, locked, frame_err, pad_err, diff_err
    );

    modport slave (
        input  DA, DACLKP, DACLKM, DAFRAMEP, DAFRAMEM,
        output data_out, data_valid, locked, frame_err, pad_err, diff_err
    );
endinterface

// File: rtl/qdr_lvds_rx.sv
// LVDS DAC link receiver: deserialises LANES lanes of SLOTS bits into DATA_W-bit samples,
// finding and tracking frame alignment with a HUNT/SYNC/LOCKED state machine.
module qdr_lvds_rx #(
    parameter int DATA_W      = 14,
    parameter int LANES       = 4,
    parameter int SLOTS       = 4,
    parameter int LOCK_FRAMES = 2
) (
    input  logic         clk,
    input  logic         reset,
    qdr_lvds_rx_if.slave link
);
    localparam int WORD_W = LANES * SLOTS;
    localparam int PAD_W  = WORD_W - DATA_W;
    localparam int SH_W   = SLOTS - 1;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1 % SLOTS);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_FRAMES);
    localparam bit                LOCK_NOW  = (LOCK_FRAMES <= 1);

    typedef enum logic [1:0] {ST_HUNT, ST_SYNC, ST_LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [GOOD_W-1:0]       good_q, good_d;
    logic                    word_ok_q, word_ok_d;
    logic [LANES*SH_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    perr_q, perr_d;
    logic                    derr_q, derr_d;
    logic [WORD_W-1:0]       word_w;
    logic [GOOD_W-1:0]       good_inc;
    logic                    frame, slot_zero, slot_last, pad_bad;

    // Each lane shifts MSB first; on the last slot the live DA bit completes the word.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign word_w[SLOTS*gi +: SLOTS] = {shift_q[SH_W*gi +: SH_W], link.DA[gi]};
            assign shift_d[SH_W*gi +: SH_W]  = word_w[SLOTS*gi +: SH_W];
        end
        if (PAD_W > 0) begin : g_pad
            assign pad_bad = |word_w[PAD_W-1:0];
        end else begin : g_nopad
            assign pad_bad = 1'b0;
        end
    endgenerate

    assign frame     = link.DAFRAMEP;
    assign slot_zero = (slot_q == '0);
    assign slot_last = (slot_q == SLOT_LAST);
    assign good_inc  = good_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        word_ok_d = word_ok_q;
        slot_d    = slot_last ? '0 : slot_q + 1'b1;
        ferr_d    = 1'b0;
        valid_d   = slot_last && !frame && word_ok_q;
        data_d    = valid_d ? word_w[WORD_W-1 -: DATA_W] : data_q;
        perr_d    = valid_d && pad_bad;
        derr_d    = (link.DAFRAMEP == link.DAFRAMEM) || (link.DACLKP == link.DACLKM);
        unique case (state_q)
            ST_HUNT: begin
                if (frame) begin
                    slot_d    = SLOT_ONE;
                    good_d    = GOOD_ONE;
                    state_d   = LOCK_NOW ? ST_LOCKED : ST_SYNC;
                    word_ok_d = LOCK_NOW;
                end
            end
            ST_SYNC: begin
                if (slot_zero) begin
                    if (frame) begin
                        good_d = good_inc;
                        if (good_inc >= GOOD_LOCK) begin
                            state_d   = ST_LOCKED;
                            word_ok_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_HUNT;
                        good_d  = '0;
                    end
                end else if (frame) begin
                    // Early marker: restart the count from this new slot 0.
                    slot_d    = SLOT_ONE;
                    good_d    = GOOD_ONE;
                    state_d   = LOCK_NOW ? ST_LOCKED : ST_SYNC;
                    word_ok_d = LOCK_NOW;
                end
            end
            ST_LOCKED: begin
                if (slot_zero && !frame) begin
                    ferr_d    = 1'b1;
                    state_d   = ST_HUNT;
                    good_d    = '0;
                    word_ok_d = 1'b0;
                end else if (!slot_zero && frame) begin
                    ferr_d    = 1'b1;
                    state_d   = ST_SYNC;
                    slot_d    = SLOT_ONE;
                    good_d    = GOOD_ONE;
                    word_ok_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_HUNT;
                good_d    = '0;
                word_ok_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_HUNT;
            slot_q    <= '0;
            good_q    <= '0;
            word_ok_q <= 1'b0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            derr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            good_q    <= good_d;
            word_ok_q <= word_ok_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            derr_q    <= derr_d;
        end
    end

    assign link.data_out   = data_q;
    assign link.data_valid = valid_q;
    assign link.locked     = (state_q == ST_LOCKED);
    assign link.frame_err  = ferr_q;
    assign link.pad_err    = perr_q;
    assign link.diff_err   = derr_q;
endmodule

// File: tb/tb_qdr_lvds_rx.sv
// Bench for qdr_lvds_rx: a per-cycle stimulus table is built first, expected outputs are derived
// from the link rules by a marker-scanning model, then the table is played and compared each cycle.
module tb_qdr_lvds_rx;
    localparam int N      = 420;
    localparam int DATA_W = 14;
    localparam int LANES  = 4;
    localparam int SLOTS  = 4;
    localparam int LF     = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qdr_lvds_rx_if #(.DATA_W(DATA_W), .LANES(LANES)) link ();

    qdr_lvds_rx #(
        .DATA_W(DATA_W), .LANES(LANES), .SLOTS(SLOTS), .LOCK_FRAMES(LF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .link (link)
    );

    logic        s_rst [N];
    logic        s_fp  [N];
    logic        s_fm  [N];
    logic        s_cp  [N];
    logic        s_cm  [N];
    logic [3:0]  s_da  [N];

    logic        e_lock  [N+1];
    logic        e_valid [N+1];
    logic        e_ferr  [N+1];
    logic        e_perr  [N+1];
    logic        e_derr  [N+1];
    logic [13:0] e_word  [N+1];
    logic [13:0] e_data  [N+1];

    int tc;
    int total;
    int bad;
    int cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cur, obs, exp);
        end
    endtask

    task automatic put_cycle(input logic fp, input logic [3:0] da);
        if (tc < N) begin
            s_rst[tc] = 1'b0;
            s_fp[tc]  = fp;
            s_fm[tc]  = ~fp;
            s_cp[tc]  = tc[0];
            s_cm[tc]  = ~tc[0];
            s_da[tc]  = da;
            tc++;
        end
    endtask

    function automatic logic [3:0] slot_bits(input logic [15:0] w, input int s);
        logic [3:0] b;
        b = '0;
        for (int k = 0; k < LANES; k++) b[k] = w[SLOTS*k + SLOTS-1 - s];
        return b;
    endfunction

    task automatic put_word(input logic [15:0] w, input int nslots, input bit marker);
        for (int s = 0; s < nslots; s++) put_cycle(marker && (s == 0), slot_bits(w, s));
    endtask

    task automatic put_idle(input int n);
        for (int i = 0; i < n; i++) put_cycle(1'b0, 4'($urandom));
    endtask

    function automatic logic [15:0] rnd_word(input bit allow_pad);
        logic [1:0] pad;
        pad = (allow_pad && ($urandom_range(0, 3) == 0)) ? 2'($urandom) : 2'b00;
        return {14'($urandom), pad};
    endfunction

    // A word whose slot 0 is at cycle a is delivered at a+SLOTS unless a marker or reset cuts it short.
    function automatic void sched(input int a);
        logic [15:0] w;
        bit ok;
        ok = 1'b1;
        w  = '0;
        if (a + SLOTS > N) return;
        for (int s = 1; s < SLOTS; s++) if (s_fp[a+s] || s_rst[a+s]) ok = 1'b0;
        if (!ok) return;
        for (int s = 0; s < SLOTS; s++)
            for (int k = 0; k < LANES; k++) w[SLOTS*k + SLOTS-1 - s] = s_da[a+s][k];
        e_valid[a+SLOTS] = 1'b1;
        e_word[a+SLOTS]  = w[15:2];
        e_perr[a+SLOTS]  = (w[1:0] != 2'b00);
    endfunction

    function automatic void build_expect();
        int mode;
        int anchor;
        int good;
        int ph;
        for (int i = 0; i <= N; i++) begin
            e_lock[i] = 0; e_valid[i] = 0; e_ferr[i] = 0; e_perr[i] = 0;
            e_derr[i] = 0; e_word[i] = '0; e_data[i] = '0;
        end
        mode = 0; anchor = 0; good = 0;
        for (int t = 0; t < N; t++) begin
            if (s_rst[t]) begin
                mode = 0;
                good = 0;
                continue;
            end
            e_derr[t+1] = (s_fp[t] == s_fm[t]) || (s_cp[t] == s_cm[t]);
            ph = (t - anchor) % SLOTS;
            case (mode)
                0: if (s_fp[t]) begin
                        anchor = t; good = 1;
                        if (good >= LF) begin mode = 2; sched(t); end else mode = 1;
                    end
                1: if (ph == 0) begin
                        if (s_fp[t]) begin
                            good++;
                            if (good >= LF) begin mode = 2; sched(t); end
                        end else mode = 0;
                    end else if (s_fp[t]) begin
                        anchor = t; good = 1;
                        if (good >= LF) begin mode = 2; sched(t); end
                    end
                default: if (ph == 0 && !s_fp[t]) begin
                        e_ferr[t+1] = 1'b1; mode = 0;
                    end else if (ph == 0) begin
                        sched(t);
                    end else if (s_fp[t]) begin
                        e_ferr[t+1] = 1'b1; mode = 1; anchor = t; good = 1;
                    end
            endcase
            e_lock[t+1] = (mode == 2);
        end
        for (int t = 0; t < N; t++)
            e_data[t+1] = s_rst[t] ? 14'h0 : (e_valid[t+1] ? e_word[t+1] : e_data[t]);
    endfunction

    initial begin
        logic [13:0] stream [4];
        int idx;
        int r;
        stream[0] = 14'h2000; stream[1] = 14'h1BC3; stream[2] = 14'h03CB; stream[3] = 14'h28B8;
        tc = 0; total = 0; bad = 0; cur = 0;

        put_idle(10);
        for (int i = 0; i < 3; i++) s_rst[i] = 1'b1;
        put_word(rnd_word(0), 4, 1);
        put_word(16'h7FFC, 4, 1);
        for (int i = 0; i < 4; i++) put_word({stream[i], 2'b00}, 4, 1);
        for (int i = 0; i < 2; i++) put_word(rnd_word(0), 4, 1);
        // marker arrives at slot 2 of a locked word
        put_word(rnd_word(0), 2, 1);
        for (int i = 0; i < 3; i++) put_word(rnd_word(0), 4, 1);
        // one marker dropped, then relock and a word with pad bits 01
        put_word(rnd_word(0), 4, 0);
        for (int i = 0; i < 3; i++) put_word(rnd_word(0), 4, 1);
        put_word({14'($urandom), 2'b01}, 4, 1);
        put_word(rnd_word(0), 4, 1);
        idx = tc + 1;
        put_word(rnd_word(0), 4, 1);
        put_word(rnd_word(0), 4, 1);
        s_fm[idx]   = s_fp[idx];
        s_cm[idx+4] = s_cp[idx+4];
        put_word(rnd_word(0), 4, 1);
        s_rst[tc-2] = 1'b1;
        put_idle(3);
        for (int i = 0; i < 3; i++) put_word(rnd_word(1), 4, 1);

        while (tc < N - 12) begin
            r = int'($urandom_range(0, 19));
            if (r == 0)      put_word(rnd_word(1), 4, 0);
            else if (r == 1) put_word(rnd_word(1), int'($urandom_range(1, 3)), 1);
            else if (r == 2) put_idle(int'($urandom_range(1, 5)));
            else if (r == 3) begin
                put_word(rnd_word(1), 4, 1);
                idx = tc - 1 - int'($urandom_range(0, 3));
                s_fm[idx] = s_fp[idx];
            end else if (r == 4) begin
                put_word(rnd_word(1), 4, 1);
                s_cm[tc-2] = s_cp[tc-2];
            end else if (r == 5) begin
                put_word(rnd_word(1), 4, 1);
                s_rst[tc-3] = 1'b1;
            end else put_word(rnd_word(1), 4, 1);
        end
        put_idle(N - tc);

        build_expect();

        for (int t = 0; t < N; t++) begin
            reset         = s_rst[t];
            link.DA       = s_da[t];
            link.DAFRAMEP = s_fp[t];
            link.DAFRAMEM = s_fm[t];
            link.DACLKP   = s_cp[t];
            link.DACLKM   = s_cm[t];
            @(posedge clk);
            #1;
            cur = t + 1;
            chk("locked",     32'(link.locked),     32'(e_lock[t+1]));
            chk("data_valid", 32'(link.data_valid), 32'(e_valid[t+1]));
            chk("data_out",   32'(link.data_out),   32'(e_data[t+1]));
            chk("frame_err",  32'(link.frame_err),  32'(e_ferr[t+1]));
            chk("pad_err",    32'(link.pad_err),    32'(e_perr[t+1]));
            chk("diff_err",   32'(link.diff_err),   32'(e_derr[t+1]));
            if (cur == 14) chk("lock_early", 32'(link.locked), 32'd0);
            if (cur == 15) chk("lock_rise",  32'(link.locked), 32'd1);
            if (cur == 18) begin
                chk("first_valid", 32'(link.data_valid), 32'd1);
                chk("first_data",  32'(link.data_out),   32'h1FFF);
                chk("first_pad",   32'(link.pad_err),    32'd0);
            end
            if (link.data_valid === 1'b1)
                $display("word cycle=%0d data=%h pad_err=%b locked=%b",
                         cur, link.data_out, link.pad_err, link.locked);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
